exu_lsu_ctrl: RTL and testbench

// - Load/store control stage directly downstream of the AGU. Accepts aligned load/store commands
//   (address, wdata, wmask, size, sign, itag), drives the single-port DTCM SRAM, and

---
 rtl/exu_lsu_ctrl.sv | 148 ++++++++++++++
 tb/tb_exu_lsu_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_lsu_ctrl.sv
// Load/store control stage behind the AGU: drives the single-port DTCM, aligns and
// extends load data, and returns load results in order through a credit-limited FIFO.
module exu_lsu_ctrl #(
   parameter int XLEN            = 32,
   parameter int DTCM_ADDR_WIDTH = 16,
   parameter int ITAG_WIDTH      = 1,
   parameter int OUTS_DEPTH      = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       lsu_cmd_valid_i,
   output logic                       lsu_cmd_ready_o,
   input  logic [DTCM_ADDR_WIDTH-1:0] lsu_cmd_addr_i,
   input  logic                       lsu_cmd_read_i,
   input  logic [XLEN-1:0]            lsu_cmd_wdata_i,
   input  logic [XLEN/8-1:0]          lsu_cmd_wmask_i,
   input  logic [1:0]                 lsu_cmd_size_i,
   input  logic                       lsu_cmd_usign_i,
   input  logic [ITAG_WIDTH-1:0]      lsu_cmd_itag_i,
   output logic                       dtcm_cs_o,
   output logic                       dtcm_we_o,
   output logic [DTCM_ADDR_WIDTH-3:0] dtcm_addr_o,
   output logic [XLEN/8-1:0]          dtcm_wem_o,
   output logic [XLEN-1:0]            dtcm_din_o,
   input  logic [XLEN-1:0]            dtcm_dout_i,
   output logic                       lsu_agu_rsp_valid_o,
   output logic                       lsu_o_valid_o,
   input  logic                       lsu_o_ready_i,
   output logic [XLEN-1:0]            lsu_o_wbck_wdat_o,
   output logic [ITAG_WIDTH-1:0]      lsu_o_wbck_itag_o
);

   localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
   localparam int CW = $clog2(OUTS_DEPTH + 1);

   logic                  issueVld_q;
   logic                  ldInflight_q;
   logic                  usign_q;
   logic [1:0]            offs_q;
   logic [1:0]            size_q;
   logic [ITAG_WIDTH-1:0] itag_q;

   logic [XLEN-1:0]       dataMem_q [OUTS_DEPTH];
   logic [ITAG_WIDTH-1:0] itagMem_q [OUTS_DEPTH];
   logic [PW-1:0]         wptr_q, wptr_d;
   logic [PW-1:0]         rptr_q, rptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [CW:0]           occ;

   logic                  hs;
   logic                  push;
   logic                  pop;
   logic [7:0]            loadByte;
   logic [15:0]           loadHalf;
   logic [XLEN-1:0]       loadData;

   function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
      if (p == PW'(OUTS_DEPTH - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   // A credit is held from acceptance of a load until its result leaves the FIFO,
   // so a push can never land on a full FIFO.
   assign occ             = {1'b0, cnt_q} + {{CW{1'b0}}, ldInflight_q};
   assign lsu_cmd_ready_o = (occ < (CW + 1)'(OUTS_DEPTH));
   assign hs              = lsu_cmd_valid_i & lsu_cmd_ready_o;

   assign dtcm_cs_o   = hs;
   assign dtcm_we_o   = hs & ~lsu_cmd_read_i;
   assign dtcm_addr_o = lsu_cmd_addr_i[DTCM_ADDR_WIDTH-1:2];
   assign dtcm_wem_o  = lsu_cmd_wmask_i & {(XLEN/8){~lsu_cmd_read_i}};
   assign dtcm_din_o  = lsu_cmd_wdata_i;

   assign lsu_agu_rsp_valid_o = issueVld_q;
   assign push                = ldInflight_q;
   assign lsu_o_valid_o       = (cnt_q != '0);
   assign pop                 = lsu_o_valid_o & lsu_o_ready_i;
   assign lsu_o_wbck_wdat_o   = dataMem_q[rptr_q];
   assign lsu_o_wbck_itag_o   = itagMem_q[rptr_q];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         issueVld_q   <= 1'b0;
         ldInflight_q <= 1'b0;
         usign_q      <= 1'b0;
         offs_q       <= 2'b00;
         size_q       <= 2'b00;
         itag_q       <= '0;
      end else begin
         issueVld_q   <= hs;
         ldInflight_q <= hs & lsu_cmd_read_i;
         usign_q      <= lsu_cmd_usign_i;
         offs_q       <= lsu_cmd_addr_i[1:0];
         size_q       <= lsu_cmd_size_i;
         itag_q       <= lsu_cmd_itag_i;
      end
   end

   always_comb begin
      loadByte = dtcm_dout_i[7:0];
      loadHalf = offs_q[1] ? dtcm_dout_i[31:16] : dtcm_dout_i[15:0];
      loadData = dtcm_dout_i;
      case (offs_q)
         2'd1:    loadByte = dtcm_dout_i[15:8];
         2'd2:    loadByte = dtcm_dout_i[23:16];
         2'd3:    loadByte = dtcm_dout_i[31:24];
         default: loadByte = dtcm_dout_i[7:0];
      endcase
      // Size 2'b11 falls through to the word case.
      case (size_q)
         2'b00:   loadData = {{(XLEN-8){loadByte[7] & ~usign_q}}, loadByte};
         2'b01:   loadData = {{(XLEN-16){loadHalf[15] & ~usign_q}}, loadHalf};
         default: loadData = dtcm_dout_i;
      endcase
   end

   always_comb begin
      wptr_d = push ? ptrInc(wptr_q) : wptr_q;
      rptr_d = pop ? ptrInc(rptr_q) : rptr_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && !rst_i) begin
         dataMem_q[wptr_q] <= loadData;
         itagMem_q[wptr_q] <= itag_q;
      end
   end

endmodule

// File: tb/tb_exu_lsu_ctrl.sv
// Scoreboard bench for exu_lsu_ctrl: directed cases plus a random soak, with a
// behavioural memory/credit model and an SRAM that answers one cycle after chip select.
module tb_exu_lsu_ctrl;

   localparam int DEPTH = 2;

   typedef struct {
      logic [31:0] data;
      logic [31:0] itag;
      int          due;
   } expT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lsu_cmd_valid = 1'b0;
   logic        lsu_cmd_ready;
   logic [15:0] lsu_cmd_addr = '0;
   logic        lsu_cmd_read = 1'b0;
   logic [31:0] lsu_cmd_wdata = '0;
   logic [3:0]  lsu_cmd_wmask = '0;
   logic [1:0]  lsu_cmd_size = '0;
   logic        lsu_cmd_usign = 1'b0;
   logic [0:0]  lsu_cmd_itag = '0;
   logic        dtcm_cs;
   logic        dtcm_we;
   logic [13:0] dtcm_addr;
   logic [3:0]  dtcm_wem;
   logic [31:0] dtcm_din;
   logic [31:0] dtcm_dout = '0;
   logic        lsu_agu_rsp_valid;
   logic        lsu_o_valid;
   logic        lsu_o_ready = 1'b1;
   logic [31:0] lsu_o_wbck_wdat;
   logic [0:0]  lsu_o_wbck_itag;

   logic [31:0] sram [16384];
   bit   [31:0] refMem [16];
   expT         expQ [$];
   int          popCyc [$];
   int          cyc = 0;
   int          accLoads = 0;
   int          popLoads = 0;
   int          lastHsCyc = -10;
   int          oReadyMode = 0;
   int          tests = 0;
   int          failures = 0;
   bit          abortRun = 1'b0;

   exu_lsu_ctrl #(.XLEN(32), .DTCM_ADDR_WIDTH(16), .ITAG_WIDTH(1), .OUTS_DEPTH(DEPTH)) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .lsu_cmd_valid_i     (lsu_cmd_valid),
      .lsu_cmd_ready_o     (lsu_cmd_ready),
      .lsu_cmd_addr_i      (lsu_cmd_addr),
      .lsu_cmd_read_i      (lsu_cmd_read),
      .lsu_cmd_wdata_i     (lsu_cmd_wdata),
      .lsu_cmd_wmask_i     (lsu_cmd_wmask),
      .lsu_cmd_size_i      (lsu_cmd_size),
      .lsu_cmd_usign_i     (lsu_cmd_usign),
      .lsu_cmd_itag_i      (lsu_cmd_itag),
      .dtcm_cs_o           (dtcm_cs),
      .dtcm_we_o           (dtcm_we),
      .dtcm_addr_o         (dtcm_addr),
      .dtcm_wem_o          (dtcm_wem),
      .dtcm_din_o          (dtcm_din),
      .dtcm_dout_i         (dtcm_dout),
      .lsu_agu_rsp_valid_o (lsu_agu_rsp_valid),
      .lsu_o_valid_o       (lsu_o_valid),
      .lsu_o_ready_i       (lsu_o_ready),
      .lsu_o_wbck_wdat_o   (lsu_o_wbck_wdat),
      .lsu_o_wbck_itag_o   (lsu_o_wbck_itag)
   );

   // Free-running clock and a cycle counter that timestamps handshakes.
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Single-port SRAM: byte-masked writes, registered read data.
   always @(posedge clk) begin
      if (dtcm_cs) begin
         if (dtcm_we) begin
            for (int b = 0; b < 4; b++) begin
               if (dtcm_wem[b]) sram[dtcm_addr][8*b +: 8] <= dtcm_din[8*b +: 8];
            end
         end else begin
            dtcm_dout <= sram[dtcm_addr];
         end
      end
   end

   // Write-back ready: held high, held low, or randomly throttled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (oReadyMode)
            0:       lsu_o_ready = 1'b1;
            1:       lsu_o_ready = 1'b0;
            default: lsu_o_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   function automatic logic [31:0] refLoad(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] sz, input bit us);
      longint v;
      if (sz == 2'd0) begin
         v = longint'((w >> (8 * off)) & 32'hFF);
         if (!us && v >= 128) v = v - 256;
      end else if (sz == 2'd1) begin
         v = longint'((w >> (16 * off[1])) & 32'hFFFF);
         if (!us && v >= 32768) v = v - 65536;
      end else begin
         v = longint'(w);
      end
      return v[31:0];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Issue one command, hold it until accepted, and record what the model expects.
   task automatic applyStimulus(input bit rd, input logic [15:0] a, input logic [31:0] wd,
                                input logic [3:0] wm, input logic [1:0] sz, input bit us,
                                input bit tg, input bit useExp, input logic [31:0] expD);
      int waited = 0;
      logic [31:0] d;
      if (abortRun) return;
      lsu_cmd_valid = 1'b1;
      lsu_cmd_read  = rd;
      lsu_cmd_addr  = a;
      lsu_cmd_wdata = wd;
      lsu_cmd_wmask = wm;
      lsu_cmd_size  = sz;
      lsu_cmd_usign = us;
      lsu_cmd_itag  = tg;
      forever begin
         @(negedge clk);
         #1;
         if (lsu_cmd_ready) break;
         waited++;
         if (waited > 60) begin
            checkOutput("cmd_accept_timeout", 32'(lsu_cmd_ready), 32'd1);
            abortRun      = 1'b1;
            lsu_cmd_valid = 1'b0;
            return;
         end
      end
      lastHsCyc = cyc;
      if (rd) begin
         d = useExp ? expD : refLoad(refMem[a[5:2]], a[1:0], sz, us);
         expQ.push_back('{d, 32'(tg), cyc + 2});
         accLoads++;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (wm[b]) refMem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
         end
      end
      @(posedge clk);
      #1;
      lsu_cmd_valid = 1'b0;
   endtask

   task automatic storeWord(input int idx, input logic [31:0] v);
      applyStimulus(1'b0, 16'(idx * 4), v, 4'hF, 2'd2, 1'b0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic loadCmd(input logic [15:0] a, input logic [1:0] sz, input bit us,
                          input bit tg, input bit useExp, input logic [31:0] expD);
      applyStimulus(1'b1, a, 32'd0, 4'h0, sz, us, tg, useExp, expD);
   endtask

   task automatic drain();
      int n = 0;
      oReadyMode = 0;
      while (expQ.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every DUT output each cycle against the credit/scoreboard model.
   initial begin
      bit expReady;
      bit expCs;
      bit expValid;
      forever begin
         @(negedge clk);
         if (rst) begin
            expQ.delete();
            accLoads  = 0;
            popLoads  = 0;
            lastHsCyc = -10;
            continue;
         end
         expReady = ((accLoads - popLoads) < DEPTH);
         checkOutput("cmd_ready", 32'(lsu_cmd_ready), 32'(expReady));
         expCs = lsu_cmd_valid && expReady;
         checkOutput("dtcm_cs", 32'(dtcm_cs), 32'(expCs));
         checkOutput("dtcm_we", 32'(dtcm_we), 32'(expCs && !lsu_cmd_read));
         if (expCs) begin
            checkOutput("dtcm_addr", 32'(dtcm_addr), 32'(lsu_cmd_addr[15:2]));
            checkOutput("dtcm_wem", 32'(dtcm_wem), lsu_cmd_read ? 32'd0 : 32'(lsu_cmd_wmask));
            checkOutput("dtcm_din", dtcm_din, lsu_cmd_wdata);
         end
         checkOutput("agu_rsp_valid", 32'(lsu_agu_rsp_valid), 32'(lastHsCyc == cyc - 1));
         expValid = (expQ.size() != 0) && (expQ[0].due <= cyc);
         checkOutput("o_valid", 32'(lsu_o_valid), 32'(expValid));
         if (expValid && lsu_o_valid && lsu_o_ready) begin
            checkOutput("wbck_wdat", lsu_o_wbck_wdat, expQ[0].data);
            checkOutput("wbck_itag", 32'(lsu_o_wbck_itag), expQ[0].itag);
            void'(expQ.pop_front());
            popLoads++;
            popCyc.push_back(cyc);
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int thirdHs;
      int w;
      logic [1:0] sz;
      logic [1:0] off;
      bit rd;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Word, byte and half loads with spec-given expected values.
      storeWord(4, 32'hDEADBEEF);
      loadCmd(16'h0010, 2'd2, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
      storeWord(4, 32'h80FF1234);
      loadCmd(16'h0013, 2'd0, 1'b0, 1'b0, 1'b1, 32'hFFFFFF80);
      loadCmd(16'h0013, 2'd0, 1'b1, 1'b1, 1'b1, 32'h00000080);
      loadCmd(16'h0010, 2'd0, 1'b0, 1'b0, 1'b1, 32'h00000034);
      storeWord(4, 32'h80017FFF);
      loadCmd(16'h0012, 2'd1, 1'b0, 1'b1, 1'b1, 32'hFFFF8001);
      loadCmd(16'h0012, 2'd1, 1'b1, 1'b0, 1'b1, 32'h00008001);
      loadCmd(16'h0010, 2'd1, 1'b0, 1'b1, 1'b1, 32'h00007FFF);
      loadCmd(16'h0010, 2'd3, 1'b1, 1'b0, 1'b1, 32'h80017FFF);

      // Byte store into a zeroed word, then read it back.
      storeWord(8, 32'h00000000);
      applyStimulus(1'b0, 16'h0022, 32'hAAAAAAAA, 4'b0100, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      loadCmd(16'h0022, 2'd0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFAA);
      loadCmd(16'h0020, 2'd2, 1'b0, 1'b0, 1'b1, 32'h00AA0000);
      drain();

      // Backpressure: two loads fill the credits, the third waits for the first pop.
      oReadyMode = 1;
      repeat (2) @(posedge clk);
      #1;
      popCyc.delete();
      loadCmd(16'h0010, 2'd2, 1'b0, 1'b0, 1'b0, 32'd0);
      loadCmd(16'h0012, 2'd1, 1'b1, 1'b1, 1'b0, 32'd0);
      fork
         loadCmd(16'h0013, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0);
         begin
            repeat (6) @(posedge clk);
            #1;
            oReadyMode = 0;
         end
      join
      thirdHs = lastHsCyc;
      drain();
      checkOutput("third_accept_cycle", 32'(thirdHs),
                  (popCyc.size() != 0) ? 32'(popCyc[0] + 1) : 32'hFFFFFFFF);

      // Reset in the cycle after a load handshake discards that load.
      loadCmd(16'h0010, 2'd2, 1'b0, 1'b1, 1'b0, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;

      // Random soak against the reference memory with throttled write-back.
      for (int i = 0; i < 16; i++) storeWord(i, $urandom);
      oReadyMode = 2;
      for (int i = 0; i < 10000 && !abortRun; i++) begin
         w   = $urandom_range(0, 15);
         sz  = 2'($urandom_range(0, 3));
         rd  = ($urandom_range(0, 9) < 6);
         off = (sz == 2'd0) ? 2'($urandom_range(0, 3)) :
               (sz == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0;
         applyStimulus(rd, {10'd0, 4'(w), off}, $urandom,
                       (sz == 2'd0) ? (4'b0001 << off) : (sz == 2'd1) ? (4'b0011 << off) : 4'hF,
                       sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 32'd0);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
